// File: rtl/match_scoreboard.sv
// N-player saturating match scoreboard: edge-detected point requests, optional
// win-by-two rule, serve hold between points and freeze once a winner is found.
module match_scoreboard #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int WIN_BY_TWO  = 0,
  parameter int HOLD_CYCLES = 50
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PLAYERS-1:0]         point_in,
  input  logic                           new_game,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [1:0]                     winner,
  output logic                           game_over,
  output logic                           serve_hold,
  output logic [NUM_PLAYERS-1:0]         point_flash
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_e;

  state_e                                 state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0]                 prev_q, prev_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_q, score_d;
  logic [1:0]                             winner_q, winner_d;
  logic                                   over_q, over_d;
  logic                                   hold_q, hold_d;
  logic [NUM_PLAYERS-1:0]                 flash_q, flash_d;

  logic [NUM_PLAYERS-1:0] rise;
  logic [NUM_PLAYERS-1:0] sel_oh;
  logic [1:0]             sel;
  logic                   hit;
  logic [SCORE_W-1:0]     inc;
  logic                   lead_ok;
  logic                   win;

  // Lowest-index rise wins; simultaneous rises from other players are dropped.
  always_comb begin
    rise   = point_in & ~prev_q;
    hit    = 1'b0;
    sel    = '0;
    sel_oh = '0;
    for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
      if (rise[i-1]) begin
        hit            = 1'b1;
        sel            = 2'(i - 1);
        sel_oh         = '0;
        sel_oh[i-1]    = 1'b1;
      end
    end
  end

  always_comb begin
    inc     = (score_q[sel] == SCORE_MAX) ? SCORE_MAX : score_q[sel] + 1'b1;
    lead_ok = 1'b1;
    for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
      if (!sel_oh[j] && ({1'b0, inc} < ({1'b0, score_q[j]} + (SCORE_W+1)'(2))))
        lead_ok = 1'b0;
    end
    // Saturation forces the win so a win-by-two match cannot stall at the ceiling.
    win = ((inc >= WIN_VAL) && ((WIN_BY_TWO == 0) || lead_ok)) ||
          ((WIN_BY_TWO != 0) && (inc == SCORE_MAX));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = point_in;
    score_d  = score_q;
    winner_d = winner_q;
    over_d   = over_q;
    hold_d   = hold_q;
    flash_d  = '0;
    if (new_game) begin
      score_d  = '0;
      over_d   = 1'b0;
      winner_d = '0;
      hold_d   = 1'b1;
      state_d  = HOLD;
      cnt_d    = HOLD_INIT;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (hit) begin
            score_d[sel] = inc;
            flash_d      = sel_oh;
            hold_d       = 1'b1;
            if (win) begin
              state_d  = OVER;
              over_d   = 1'b1;
              winner_d = sel;
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_INIT;
            end
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = PLAY;
            hold_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        OVER: ;
        default: begin
          state_d = HOLD;
          cnt_d   = HOLD_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HOLD;
      cnt_q    <= HOLD_INIT;
      prev_q   <= '1;
      score_q  <= '0;
      winner_q <= '0;
      over_q   <= 1'b0;
      hold_q   <= 1'b1;
      flash_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      score_q  <= score_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      hold_q   <= hold_d;
      flash_q  <= flash_d;
    end
  end

  assign scores      = score_q;
  assign winner      = winner_q;
  assign game_over   = over_q;
  assign serve_hold  = hold_q;
  assign point_flash = flash_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Bench for match_scoreboard: two configurations (2-player default, 3-player
// win-by-two with short hold) checked every cycle against a behavioural model.
module tb_match_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pin0;
  logic [2:0]  pin1;
  logic        ng0, ng1;
  logic [7:0]  scores0;
  logic [11:0] scores1;
  logic [1:0]  winner0, winner1;
  logic        go0, go1, sh0, sh1;
  logic [1:0]  flash0;
  logic [2:0]  flash1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  match_scoreboard #(.NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(0), .HOLD_CYCLES(50)) dut0 (
    .clk(clk), .rst(rst), .point_in(pin0), .new_game(ng0), .scores(scores0), .winner(winner0),
    .game_over(go0), .serve_hold(sh0), .point_flash(flash0));

  match_scoreboard #(.NUM_PLAYERS(3), .SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(1), .HOLD_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .point_in(pin1), .new_game(ng1), .scores(scores1), .winner(winner1),
    .game_over(go1), .serve_hold(sh1), .point_flash(flash1));

  // Model: per unit, scores, remaining hold cycles, over flag, winner, flash.
  int         m_score [2][4];
  logic [3:0] m_prev  [2];
  bit         m_over  [2];
  int         m_winner[2];
  int         m_hold  [2];
  logic [3:0] m_flash [2];

  task automatic model_reset(input int k, input int hc);
    for (int p = 0; p < 4; p++) m_score[k][p] = 0;
    m_prev[k]   = 4'b1111;
    m_over[k]   = 1'b0;
    m_winner[k] = 0;
    m_hold[k]   = hc;
    m_flash[k]  = '0;
  endtask

  task automatic model_step(input int k, input int np, input int hc, input int wb2,
                            input logic [3:0] pin, input bit ng);
    logic [3:0] rise;
    int i, ns;
    bit win;
    rise       = pin & ~m_prev[k];
    m_prev[k]  = pin;
    m_flash[k] = '0;
    if (ng) begin
      for (int p = 0; p < 4; p++) m_score[k][p] = 0;
      m_over[k]   = 1'b0;
      m_winner[k] = 0;
      m_hold[k]   = hc;
    end else if (m_over[k]) begin
    end else if (m_hold[k] > 0) begin
      m_hold[k]--;
    end else if (rise != 0) begin
      i = 0;
      while (!rise[i]) i++;
      ns = (m_score[k][i] < 15) ? m_score[k][i] + 1 : 15;
      m_score[k][i] = ns;
      m_flash[k][i] = 1'b1;
      win = (ns >= 9);
      if (wb2 != 0) begin
        for (int p = 0; p < np; p++)
          if (p != i && ns < m_score[k][p] + 2) win = 1'b0;
        if (ns == 15) win = 1'b1;
      end
      if (win) begin
        m_over[k]   = 1'b1;
        m_winner[k] = i;
      end else begin
        m_hold[k] = hc;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset(0, 50);
      model_reset(1, 3);
    end else begin
      model_step(0, 2, 50, 0, {2'b00, pin0}, ng0);
      model_step(1, 3, 3, 1, {1'b0, pin1}, ng1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e0, e1;
    e0 = '0;
    e1 = '0;
    for (int p = 0; p < 2; p++) e0[p*4 +: 4] = 4'(m_score[0][p]);
    for (int p = 0; p < 3; p++) e1[p*4 +: 4] = 4'(m_score[1][p]);
    check("scores0", 32'(scores0), e0);
    check("winner0", 32'(winner0), 32'(m_winner[0]));
    check("over0",   32'(go0),     32'(m_over[0]));
    check("hold0",   32'(sh0),     32'(m_over[0] || m_hold[0] > 0));
    check("flash0",  32'(flash0),  32'(m_flash[0][1:0]));
    check("scores1", 32'(scores1), e1);
    check("winner1", 32'(winner1), 32'(m_winner[1]));
    check("over1",   32'(go1),     32'(m_over[1]));
    check("hold1",   32'(sh1),     32'(m_over[1] || m_hold[1] > 0));
    check("flash1",  32'(flash1),  32'(m_flash[1][2:0]));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse0(input logic [1:0] m, input int gap);
    pin0 = m;
    tick(1);
    pin0 = '0;
    tick(gap);
  endtask

  task automatic pulse1(input logic [2:0] m);
    pin1 = m;
    tick(1);
    pin1 = '0;
    tick(5);
  endtask

  initial begin
    rst  = 1'b0;
    pin0 = 2'b01;
    pin1 = '0;
    ng0  = 1'b0;
    ng1  = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(49);
    check("lit_hold_49", 32'(sh0), 32'd1);
    check("lit_noscore_reset", 32'(scores0), 32'h00);
    tick(1);
    check("lit_hold_50", 32'(sh0), 32'd0);
    pin0 = '0;
    tick(2);

    repeat (9) pulse0(2'b10, 60);
    check("lit_p1_nine", 32'(scores0), 32'h90);
    check("lit_over", 32'(go0), 32'd1);
    check("lit_winner1", 32'(winner0), 32'd1);
    pulse0(2'b10, 5);
    check("lit_frozen", 32'(scores0), 32'h90);

    ng0 = 1'b1;
    tick(1);
    ng0 = 1'b0;
    check("lit_ng_over_scores", 32'(scores0), 32'h00);
    check("lit_ng_over_go", 32'(go0), 32'd0);
    check("lit_ng_over_hold", 32'(sh0), 32'd1);
    tick(60);

    pin0 = 2'b11;
    tick(1);
    pin0 = '0;
    check("lit_both_flash", 32'(flash0), 32'h1);
    check("lit_both_scores", 32'(scores0), 32'h01);
    tick(9);
    pin0 = 2'b10;
    tick(1);
    pin0 = '0;
    check("lit_hold_ignored", 32'(scores0), 32'h01);
    check("lit_hold_noflash", 32'(flash0), 32'h0);
    tick(60);

    pulse0(2'b10, 5);
    check("lit_pre_ng_hold", 32'(scores0), 32'h11);
    ng0 = 1'b1;
    tick(1);
    ng0 = 1'b0;
    check("lit_ng_hold_scores", 32'(scores0), 32'h00);
    check("lit_ng_hold_hold", 32'(sh0), 32'd1);
    tick(60);

    pin0 = 2'b01;
    ng0  = 1'b1;
    tick(1);
    ng0  = 1'b0;
    pin0 = '0;
    check("lit_ng_priority", 32'(scores0), 32'h00);
    check("lit_ng_priority_flash", 32'(flash0), 32'h0);
    tick(60);

    pulse0(2'b01, 60);
    check("lit_pre_rst", 32'(scores0), 32'h01);
    rst = 1'b0;
    #1;
    check("lit_rst_scores", 32'(scores0), 32'h00);
    check("lit_rst_hold", 32'(sh0), 32'd1);
    check("lit_rst_go", 32'(go0), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(5);

    repeat (9) begin
      pulse1(3'b001);
      pulse1(3'b010);
    end
    check("lit_w2_9_9", 32'(scores1), 32'h099);
    pulse1(3'b001);
    check("lit_w2_10_9", 32'(scores1), 32'h09A);
    check("lit_w2_10_9_go", 32'(go1), 32'd0);
    pulse1(3'b001);
    check("lit_w2_11_9", 32'(scores1), 32'h09B);
    check("lit_w2_11_9_go", 32'(go1), 32'd1);
    check("lit_w2_winner0", 32'(winner1), 32'd0);

    ng1 = 1'b1;
    tick(1);
    ng1 = 1'b0;
    tick(5);
    repeat (14) begin
      pulse1(3'b001);
      pulse1(3'b010);
    end
    check("lit_w2_14_14", 32'(scores1), 32'h0EE);
    check("lit_w2_14_14_go", 32'(go1), 32'd0);
    pulse1(3'b001);
    check("lit_sat_scores", 32'(scores1), 32'h0EF);
    check("lit_sat_go", 32'(go1), 32'd1);
    check("lit_sat_winner", 32'(winner1), 32'd0);

    ng1 = 1'b1;
    tick(1);
    ng1 = 1'b0;
    tick(5);
    repeat (9) pulse1(3'b100);
    check("lit_p2_scores", 32'(scores1), 32'h900);
    check("lit_p2_winner", 32'(winner1), 32'd2);

    ng1 = 1'b1;
    tick(1);
    ng1 = 1'b0;
    repeat (4000) begin
      pin0 = 2'($urandom);
      pin1 = 3'($urandom);
      ng0  = ($urandom_range(0, 299) == 0);
      ng1  = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    pin0 = '0;
    pin1 = '0;
    ng0  = 1'b0;
    ng1  = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
